// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//
// Purpose:
//   Bundles the two buses of the boot-time program loader:
//     - the byte stream from the boot source (valid/ready handshake), and
//     - the write port into the instruction memory.
//
// Signals:
//   rx_valid  source presents a byte on rx_data
//   rx_data   byte value (8 bits)
//   rx_ready  loader accepts the presented byte this cycle
//   im_we     instruction-memory write strobe
//   im_addr   word-aligned byte address of the write (32 bits)
//   im_wdata  instruction word to write (32 bits)
//
// Modports:
//   master  the loader: consumes the byte stream, drives the memory port
//   slave   the environment: boot source plus instruction memory
// ---------------------------------------------------------------------------
interface imem_loader_if;

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;

  modport master (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output im_we,
    output im_addr,
    output im_wdata
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  im_we,
    input  im_addr,
    input  im_wdata
  );

endinterface : imem_loader_if

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Boot-time program loader for the pipelined datapath. A load is started
//   with a single-cycle load_start pulse. The loader then receives a byte
//   frame over a valid/ready stream:
//     - 2 header bytes: word count N, MSB first
//     - N words of 4 bytes each, MSB first (big-endian)
//     - optionally one checksum byte (see below)
//   Each assembled word is written to the instruction memory at consecutive
//   word-aligned addresses starting at 0. The datapath is held in reset
//   (core_reset = 1) until a complete, valid image has been written; it is
//   then released so fetch starts at PC = 0.
//
// Parameters:
//   ADDR_W  instruction-memory word-address width, capacity 2^ADDR_W words.
//           Must be in the range 1..14 so the address and count arithmetic
//           below fits the 32-bit address and the 16-bit header count.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous reset, active low (0 = in reset)
//   load_start  single-cycle pulse, starts a load from IDLE/DONE/ERR
//   bus         imem_loader_if.master: byte stream in, memory write port out
//   core_reset  active-high reset to the datapath (low only in DONE)
//   busy        load in progress
//   done        last load completed successfully
//   err         last load aborted (oversized header or bad checksum)
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN):
//   When defined, a CSUM state follows the last word (or an empty image).
//   It consumes one byte that must equal the XOR of all payload bytes
//   (header excluded, 0x00 for N = 0); a match completes the load, a
//   mismatch aborts it. When undefined there is no CSUM state, no checksum
//   byte is consumed and no XOR logic exists.
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  imem_loader_if.master bus,
  output logic          core_reset,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // Largest legal word count: exactly fills the memory.
  localparam logic [16:0]     N_MAX   = 17'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    WORD   = 3'd3,
    WRITE  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM   = 3'd5,
`endif
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  // State entered once the whole payload has been written.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FINAL_STATE = CSUM;
`else
  localparam state_t FINAL_STATE = DONE;
`endif

  state_t          state_q, state_d;
  logic [15:0]     n_q, n_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [23:0]     word_q, word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic            rx_ready_q, rx_ready_d;
  logic            im_we_q, im_we_d;
  logic [31:0]     im_addr_q, im_addr_d;
  logic [31:0]     im_wdata_q, im_wdata_d;
  logic            core_reset_q, core_reset_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            accept;
  logic [15:0]     hdr_n;
  logic [ADDR_W:0] idx_inc;
  logic            last_word;
  logic [31:0]     word_addr;

  assign accept    = bus.rx_valid & rx_ready_q;
  assign hdr_n     = {n_q[15:8], bus.rx_data};
  assign idx_inc   = idx_q + IDX_ONE;
  // The index is ADDR_W+1 bits so that N = 2^ADDR_W is reachable without wrap.
  assign last_word = ({{(15 - ADDR_W){1'b0}}, idx_inc} == n_q);
  assign word_addr = {{(29 - ADDR_W){1'b0}}, idx_q, 2'b00};

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // All outputs are registered so the handshake and memory port are glitch
  // free; each is decoded from the next state, so it lines up with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ready_q   <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rx_ready_q   <= rx_ready_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic: frame parsing, word assembly and memory writes.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (load_start) begin
          state_d    = HDR_HI;
          n_d        = '0;
          idx_d      = '0;
          byte_cnt_d = '0;
          word_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end

      HDR_HI: begin
        if (accept) begin
          n_d     = {bus.rx_data, n_q[7:0]};
          state_d = HDR_LO;
        end
      end

      HDR_LO: begin
        if (accept) begin
          n_d = hdr_n;
          if ({1'b0, hdr_n} > N_MAX) begin
            state_d = ERR;
          end else if (hdr_n == 16'd0) begin
            state_d = FINAL_STATE;
          end else begin
            state_d = WORD;
          end
        end
      end

      // The first three bytes are kept in word_q; the fourth goes straight
      // into the write-data register so the strobe fires on the next cycle.
      WORD: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            im_wdata_d = {word_q, bus.rx_data};
            im_addr_d  = word_addr;
            byte_cnt_d = '0;
            state_d    = WRITE;
          end else begin
            word_d     = {word_q[15:0], bus.rx_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      WRITE: begin
        idx_d = idx_inc;
        if (last_word) begin
          state_d = FINAL_STATE;
        end else begin
          state_d = WORD;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          if (bus.rx_data == csum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERR;
          end
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state.
  always_comb begin
    rx_ready_d   = 1'b0;
    im_we_d      = 1'b0;
    core_reset_d = 1'b1;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_d)
      HDR_HI, HDR_LO, WORD: begin
        rx_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        rx_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
`endif
      WRITE: begin
        im_we_d = 1'b1;
        busy_d  = 1'b1;
      end
      DONE: begin
        core_reset_d = 1'b0;
        done_d       = 1'b1;
      end
      ERR: begin
        err_d = 1'b1;
      end
      default: begin
        rx_ready_d = 1'b0;
      end
    endcase
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;
  assign core_reset   = core_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

  // A byte must never be taken while the write strobe is up.
  a_no_accept_in_write : assert property (
    @(posedge clk) disable iff (!reset) im_we_q |-> !rx_ready_q
  );

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader (ADDR_W = 8). A table of frame
// descriptions is applied in a loop; expected memory writes are queued as
// each word is driven and popped by a monitor when im_we is seen. A few
// hand-written sequences cover exact cycle timing, the empty image and an
// asynchronous reset in the middle of a word. Builds with or without
// IMEM_LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic reset;
  logic load_start;
  logic core_reset;
  logic busy;
  logic done;
  logic err;

  imem_loader_if bus_if ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .bus        (bus_if.master),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned n_hdr;
    bit          toggle;
    bit          bad_csum;
    bit          exp_done;
    bit          exp_err;
    int unsigned exp_writes;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  int          write_count = 0;
  wr_t         sb_q[$];
  logic [31:0] tx_words[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory-side monitor: every write strobe must match the oldest queued word.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (reset === 1'b1 && bus_if.im_we === 1'b1) begin
      write_count++;
      checkOutput("rx_ready_during_write", {31'd0, bus_if.rx_ready}, 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write: got addr 0x%08h expected no write", bus_if.im_addr);
      end else begin
        e = sb_q.pop_front();
        checkOutput("im_addr", bus_if.im_addr, e.addr);
        checkOutput("im_wdata", bus_if.im_wdata, e.data);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_rx_ready"}, {31'd0, bus_if.rx_ready}, 32'd0);
    checkOutput({tag, "_im_we"}, {31'd0, bus_if.im_we}, 32'd0);
    checkOutput({tag, "_im_addr"}, bus_if.im_addr, 32'd0);
    checkOutput({tag, "_im_wdata"}, bus_if.im_wdata, 32'd0);
    checkOutput({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  // Presents one byte until accepted. In toggle mode valid drops for one
  // cycle afterwards; load_start may be pulsed during that bubble.
  task automatic send_byte(input logic [7:0] b, input bit toggle, input bit pulse_start);
    bit acc = 1'b0;
    int budget = 0;
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = b;
    while (!acc && budget < 40) begin
      @(negedge clk);
      acc = bus_if.rx_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    bus_if.rx_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("[TB] FAIL byte_timeout: got no rx_ready in 40 cycles expected acceptance of 0x%02h", b);
    end
    if (toggle) begin
      load_start = pulse_start;
      @(posedge clk);
      #1;
      load_start = 1'b0;
    end
  endtask

  task automatic start_load();
    @(posedge clk);
    #1;
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    write_count = 0;
  endtask

  // Sends all words in tx_words, queueing the expected writes; returns XOR.
  task automatic send_payload(input bit toggle, output logic [7:0] csum);
    logic [31:0] w;
    wr_t e;
    csum = 8'h00;
    for (int i = 0; i < tx_words.size(); i++) begin
      w = tx_words[i];
      e.addr = 32'(i) << 2;
      e.data = w;
      sb_q.push_back(e);
      for (int k = 3; k >= 0; k--) begin
        csum = csum ^ w[8*k +: 8];
        send_byte(w[8*k +: 8], toggle, toggle && i == 0 && k == 2);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    logic [7:0] csum;
    logic [15:0] n16;
    int budget = 0;
    n16 = 16'(v.n_hdr);
    start_load();
    checkOutput({name, "_busy_at_start"}, {31'd0, busy}, 32'd1);
    checkOutput({name, "_done_cleared"}, {31'd0, done}, 32'd0);
    checkOutput({name, "_err_cleared"}, {31'd0, err}, 32'd0);
    send_byte(n16[15:8], v.toggle, 1'b0);
    send_byte(n16[7:0], v.toggle, 1'b0);
    if (v.n_hdr <= (1 << ADDR_W)) begin
      send_payload(v.toggle, csum);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(v.bad_csum ? (csum ^ 8'h01) : csum, v.toggle, 1'b0);
`endif
    end
    while (!(done || err) && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    checkOutput({name, "_done"}, {31'd0, done}, {31'd0, v.exp_done});
    checkOutput({name, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    checkOutput({name, "_core_reset"}, {31'd0, core_reset}, {31'd0, !v.exp_done});
    checkOutput({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_write_count"}, 32'(write_count), 32'(v.exp_writes));
    checkOutput({name, "_pending_writes"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  // N=2, continuous valid: strobe one cycle after the 4th byte, done and
  // core_reset release on the edge after the last write (or checksum).
  task automatic run_timing_case();
    logic [7:0] csum;
    tx_words = '{32'h20080005, 32'h2009000A};
    start_load();
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_payload(1'b0, csum);
    @(negedge clk);
    checkOutput("t2_last_write_latency", {31'd0, bus_if.im_we}, 32'd1);
    checkOutput("t2_done_low_in_write", {31'd0, done}, 32'd0);
    checkOutput("t2_core_held_in_write", {31'd0, core_reset}, 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum, 1'b0, 1'b0);
`endif
    @(negedge clk);
    checkOutput("t2_done", {31'd0, done}, 32'd1);
    checkOutput("t2_core_released", {31'd0, core_reset}, 32'd0);
    checkOutput("t2_write_count", 32'(write_count), 32'd2);
    sb_q.delete();
  endtask

  // N=0: nothing written, done in the cycle after the final accepted byte.
  task automatic run_empty_case();
    start_load();
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b0, 1'b0);
`endif
    @(negedge clk);
    checkOutput("n0_done", {31'd0, done}, 32'd1);
    checkOutput("n0_err", {31'd0, err}, 32'd0);
    checkOutput("n0_core_released", {31'd0, core_reset}, 32'd0);
    checkOutput("n0_write_count", 32'(write_count), 32'd0);
  endtask

  // Async reset after two bytes of word 1, then a clean full load.
  task automatic run_reset_case();
    vec_t v;
    start_load();
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'hAB, 1'b0, 1'b0);
    send_byte(8'hCD, 1'b0, 1'b0);
    checkOutput("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    tx_words = '{32'h20080005, 32'h2009000A};
    v = '{n_hdr: 2, toggle: 1'b0, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 2};
    applyStimulus(v, "after_rst");
  endtask

  vec_t vecs[8];
  int   nvec;

  initial begin
    nvec = 0;
    vecs[nvec++] = '{n_hdr: 1,   toggle: 1'b0, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 1};
    vecs[nvec++] = '{n_hdr: 3,   toggle: 1'b1, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 3};
    vecs[nvec++] = '{n_hdr: 257, toggle: 1'b0, bad_csum: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 0};
    vecs[nvec++] = '{n_hdr: 256, toggle: 1'b0, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 256};
    vecs[nvec++] = '{n_hdr: 5,   toggle: 1'b1, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 5};
    vecs[nvec++] = '{n_hdr: 2,   toggle: 1'b0, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 2};
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs[nvec++] = '{n_hdr: 4,   toggle: 1'b0, bad_csum: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 4};
    vecs[nvec++] = '{n_hdr: 3,   toggle: 1'b1, bad_csum: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 3};
`endif

    reset           = 1'b0;
    load_start      = 1'b0;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    @(negedge clk);
    reset = 1'b1;

    run_timing_case();
    run_empty_case();

    for (int i = 0; i < nvec; i++) begin
      tx_words.delete();
      if (vecs[i].n_hdr <= (1 << ADDR_W)) begin
        for (int j = 0; j < int'(vecs[i].n_hdr); j++) begin
          tx_words.push_back($urandom);
        end
      end
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    begin
      vec_t v;
      tx_words = '{32'h01020304};
      v = '{n_hdr: 1, toggle: 1'b0, bad_csum: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 1};
      applyStimulus(v, "csum_good");
      tx_words = '{32'h01020304};
      v = '{n_hdr: 1, toggle: 1'b0, bad_csum: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 1};
      applyStimulus(v, "csum_bad");
    end
`endif

    run_reset_case();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_imem_loader
